// File: rtl/ca_ingr_rcv_responder.sv
// Responder end of the ingress receive req/resp/data protocol: grants a burst
// against upstream availability, answers with a response, then passes the beats through.
module ca_ingr_rcv_responder #(
    parameter int MAX_BURST = 4096
) (
    input  logic         ap_clk,
    input  logic         ap_rst,
    input  logic         req_tvalid,
    output logic         req_tready,
    input  logic [63:0]  req_tdata,
    output logic         resp_tvalid,
    input  logic         resp_tready,
    output logic [63:0]  resp_tdata,
    input  logic [31:0]  src_avail,
    input  logic         src_tvalid,
    output logic         src_tready,
    input  logic [511:0] src_tdata,
    output logic         data_tvalid,
    input  logic         data_tready,
    output logic [511:0] data_tdata,
    output logic         grant_vld,
    output logic [15:0]  grant_bytes,
    output logic [1:0]   err_status,
    input  logic         err_clear
);

    typedef enum logic [1:0] {IDLE, RESP, DATA} state_t;

    localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);

    state_t        state_reg, state_next;
    logic [15:0]   grant_reg;
    logic [10:0]   beat_cnt_reg;
    logic [63:0]   resp_data_reg;
    logic          grant_vld_reg;
    logic [15:0]   grant_bytes_reg;
    logic [1:0]    err_reg;

    logic [15:0]   burst_len;
    logic [31:0]   len_w;
    logic [31:0]   grant_w;
    logic [15:0]   grant_calc;
    logic [1:0]    err_set;
    logic [16:0]   grant_round;
    logic [10:0]   beats_calc;
    logic          req_hs, resp_hs, beat_hs;
    logic          unused_req_bits;

    assign burst_len       = req_tdata[63:48];
    assign unused_req_bits = ^{req_tdata[47:32], req_tdata[29:9]};

    // Compare at full 32-bit width so a huge src_avail cannot alias after truncation.
    always_comb begin
        len_w   = {16'h0, burst_len};
        grant_w = len_w;
        if (src_avail < grant_w)
            grant_w = src_avail;
        if (MAX_BURST_W < grant_w)
            grant_w = MAX_BURST_W;
        grant_calc = grant_w[15:0];
        err_set[0] = (burst_len == 16'h0);
        err_set[1] = (len_w > MAX_BURST_W);
    end

    assign grant_round = {1'b0, grant_reg} + 17'd63;
    assign beats_calc  = grant_round[16:6];

    always_ff @(posedge ap_clk) begin
        if (ap_rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Every handshake output is gated by reset so nothing handshakes while ap_rst is high.
    always_comb begin
        state_next  = state_reg;
        req_tready  = 1'b0;
        resp_tvalid = 1'b0;
        data_tvalid = 1'b0;
        src_tready  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_tready = !ap_rst;
                if (req_tvalid && !ap_rst)
                    state_next = RESP;
            end
            RESP: begin
                resp_tvalid = !ap_rst;
                if (resp_tready)
                    state_next = (grant_reg == 16'h0) ? IDLE : DATA;
            end
            DATA: begin
                data_tvalid = src_tvalid && !ap_rst;
                src_tready  = data_tready && !ap_rst;
                if (src_tvalid && data_tready && beat_cnt_reg == 11'd1)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_hs  = req_tvalid && req_tready;
    assign resp_hs = resp_tvalid && resp_tready;
    assign beat_hs = data_tvalid && data_tready;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            grant_reg       <= 16'h0;
            beat_cnt_reg    <= 11'h0;
            resp_data_reg   <= 64'h0;
            grant_vld_reg   <= 1'b0;
            grant_bytes_reg <= 16'h0;
        end else begin
            grant_vld_reg <= 1'b0;
            if (req_hs) begin
                grant_reg     <= grant_calc;
                resp_data_reg <= {grant_calc, 16'h0, req_tdata[31], req_tdata[30],
                                  21'h0, req_tdata[8:0]};
            end
            if (resp_hs) begin
                grant_vld_reg   <= 1'b1;
                grant_bytes_reg <= grant_reg;
                beat_cnt_reg    <= beats_calc;
            end else if (beat_hs) begin
                beat_cnt_reg <= beat_cnt_reg - 11'd1;
            end
        end
    end

    // Sticky flags: a set from a request handshake beats a simultaneous clear.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_err
            always_ff @(posedge ap_clk) begin
                if (ap_rst)
                    err_reg[gi] <= 1'b0;
                else if (req_hs && err_set[gi])
                    err_reg[gi] <= 1'b1;
                else if (err_clear)
                    err_reg[gi] <= 1'b0;
            end
        end
    endgenerate

    assign resp_tdata  = resp_data_reg;
    assign data_tdata  = src_tdata;
    assign grant_vld   = grant_vld_reg;
    assign grant_bytes = grant_bytes_reg;
    assign err_status  = err_reg;

endmodule
